// File: rtl/fp_mul_arbiter_pkg.sv
// Shared fixed-point definitions: word/fraction widths, the fp type and a reference multiply.
`ifndef NUM_ALL_DIGITS
`define NUM_ALL_DIGITS 32
`endif
`ifndef NUM_FRAC_DIGITS
`define NUM_FRAC_DIGITS 16
`endif

package fp_mul_arbiter_pkg;

  localparam int unsigned FP_W = `NUM_ALL_DIGITS;
  localparam int unsigned FP_F = `NUM_FRAC_DIGITS;

  typedef logic signed [FP_W-1:0] fp;

  // Full-width signed product, floor-shifted by the fraction width, wrapped to FP_W bits.
  function automatic fp fp_mul(input fp a, input fp b);
    logic signed [2*FP_W-1:0] a_ext;
    logic signed [2*FP_W-1:0] b_ext;
    logic signed [2*FP_W-1:0] prod;
    a_ext = {{FP_W{a[FP_W-1]}}, a};
    b_ext = {{FP_W{b[FP_W-1]}}, b};
    prod  = (a_ext * b_ext) >>> FP_F;
    return prod[FP_W-1:0];
  endfunction

endpackage

// File: rtl/fp_mul_arbiter_mul_pipe.sv
// Fixed-latency signed fixed-point multiplier; valid, tag and product travel together.
module fp_mul_pipe #(
  parameter int unsigned W           = 32,
  parameter int unsigned F           = 16,
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned TAG_W       = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [W-1:0]     out_data,
  output logic             busy
);

  // Only the low W+F product bits survive the shift-and-truncate, so W+F is enough width.
  logic signed [W+F-1:0] a_ext;
  logic signed [W+F-1:0] b_ext;
  logic signed [W+F-1:0] prod_full;
  logic [W-1:0]          prod;
  logic                  unused_frac;

  always_comb begin
    a_ext     = {{F{in_a[W-1]}}, in_a};
    b_ext     = {{F{in_b[W-1]}}, in_b};
    prod_full = a_ext * b_ext;
    prod      = prod_full[W+F-1:F];
  end

  assign unused_frac = ^prod_full[F-1:0];

  logic [MUL_LATENCY-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q  [MUL_LATENCY];
  logic [W-1:0]           data_q [MUL_LATENCY];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
      for (int s = 0; s < MUL_LATENCY; s++) begin
        tag_q[s]  <= '0;
        data_q[s] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      tag_q[0]   <= in_tag;
      data_q[0]  <= prod;
      for (int s = 1; s < MUL_LATENCY; s++) begin
        valid_q[s] <= valid_q[s-1];
        tag_q[s]   <= tag_q[s-1];
        data_q[s]  <= data_q[s-1];
      end
    end
  end

  assign out_valid = valid_q[MUL_LATENCY-1];
  assign out_tag   = tag_q[MUL_LATENCY-1];
  assign out_data  = data_q[MUL_LATENCY-1];
  assign busy      = |valid_q;

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined fixed-point multiplier among NUM_REQ requesters.
module fp_mul_arbiter
  import fp_mul_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [NUM_REQ-1:0]      req_valid_in,
  input  logic [NUM_REQ*FP_W-1:0] req_a_in,
  input  logic [NUM_REQ*FP_W-1:0] req_b_in,
  output logic [NUM_REQ-1:0]      req_ready_out,
  output logic [NUM_REQ-1:0]      resp_valid_out,
  output logic [FP_W-1:0]         resp_data_out,
  output logic                    busy_out
);

  localparam int unsigned W     = FP_W;
  localparam int unsigned F     = FP_F;
  localparam int unsigned TAG_W = $clog2(NUM_REQ);

  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0] grant_idx;
  logic [TAG_W-1:0] cand_idx;
  logic             grant_found;
  logic             accept;
  logic             rst_hold_q;
  int unsigned      cand;

  always_comb begin
    grant_found   = 1'b0;
    grant_idx     = '0;
    cand          = 0;
    cand_idx      = '0;
    req_ready_out = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = TAG_W'(cand);
      if (!grant_found && req_valid_in[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    // No grants while reset is applied or in the first cycle after it.
    if (grant_found && !rst_in && !rst_hold_q) req_ready_out[grant_idx] = 1'b1;
  end

  assign accept = |req_ready_out;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr_q   <= '0;
      rst_hold_q <= 1'b1;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rst_hold_q <= 1'b0;
    end
  end

  logic             pipe_valid;
  logic [TAG_W-1:0] pipe_tag;
  logic [W-1:0]     pipe_data;
  logic             pipe_busy;

  fp_mul_pipe #(
    .W           (W),
    .F           (F),
    .MUL_LATENCY (MUL_LATENCY),
    .TAG_W       (TAG_W)
  ) u_mul_pipe (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .in_valid  (accept),
    .in_tag    (grant_idx),
    .in_a      (req_a_in[grant_idx*W +: W]),
    .in_b      (req_b_in[grant_idx*W +: W]),
    .out_valid (pipe_valid),
    .out_tag   (pipe_tag),
    .out_data  (pipe_data),
    .busy      (pipe_busy)
  );

  always_comb begin
    resp_valid_out = '0;
    if (pipe_valid && !rst_in) resp_valid_out[pipe_tag] = 1'b1;
    resp_data_out = rst_in ? '0 : pipe_data;
    busy_out      = pipe_busy & ~rst_in;
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed and random checks of fp_mul_arbiter against an arbitration model and a response scoreboard.
module tb_fp_mul_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned LAT = 3;
  localparam int unsigned W   = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   valid;
  logic [NR*W-1:0] a_bus, b_bus;
  logic [NR-1:0]   ready, resp_valid;
  logic [W-1:0]    resp_data;
  logic            busy;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.NUM_REQ(NR), .MUL_LATENCY(LAT)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .req_valid_in   (valid),
    .req_a_in       (a_bus),
    .req_b_in       (b_bus),
    .req_ready_out  (ready),
    .resp_valid_out (resp_valid),
    .resp_data_out  (resp_data),
    .busy_out       (busy)
  );

  typedef struct {
    int          tag;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          grant_log[$];
  logic [31:0] resp_log[$];
  int checks = 0, errors = 0, cyc = 0, grant_total = 0;
  int m_rr = 0, last_g = -1;
  bit m_hold = 1'b0;
  int wait_cnt[NR];

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] pa, pb, p;
    pa = {{32{a[31]}}, a};
    pb = {{32{b[31]}}, b};
    p  = pa * pb;
    p  = p >>> 16;
    return p[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    a_bus[i*W +: W] = a;
    b_bus[i*W +: W] = b;
  endtask

  // One clock: check outputs at the falling edge, then advance past the rising edge.
  task automatic tick();
    logic [NR-1:0] exp_ready, exp_resp;
    int g;
    exp_t e;
    @(negedge clk);
    exp_ready = '0;
    g = -1;
    if (!rst && !m_hold) begin
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_rr + k) % NR;
        if (g < 0 && valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("ready", ready, exp_ready);
    chk("busy", busy, (!rst && sb.size() > 0));
    exp_resp = '0;
    if (rst || m_hold) begin
      chk("reset_resp_valid", resp_valid, 0);
      chk("reset_resp_data", resp_data, 0);
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_resp[sb[0].tag] = 1'b1;
      chk("resp_valid", resp_valid, exp_resp);
      chk("resp_data", resp_data, sb[0].data);
      resp_log.push_back(resp_data);
      void'(sb.pop_front());
    end else begin
      chk("resp_idle", resp_valid, 0);
    end
    if (g >= 0) begin
      for (int i = 0; i < NR; i++) begin
        if (valid[i] && i != g) begin
          wait_cnt[i]++;
          chk("starvation", (wait_cnt[i] < NR), 1);
        end else begin
          wait_cnt[i] = 0;
        end
      end
      e.tag  = g;
      e.data = ref_mul(a_bus[g*W +: W], b_bus[g*W +: W]);
      e.due  = cyc + LAT;
      sb.push_back(e);
      grant_log.push_back(g);
      grant_total++;
    end
    last_g = g;
    @(posedge clk);
    if (rst) begin
      sb.delete();
      m_rr   = 0;
      m_hold = 1'b1;
      for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    end else begin
      m_hold = 1'b0;
      if (g >= 0) m_rr = (g + 1) % NR;
    end
    #1;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    rst = 1'b1; valid = '0; a_bus = '0; b_bus = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single request, 1.5 * 2.0
    resp_log.delete();
    set_op(0, 32'h00018000, 32'h00020000);
    valid = 4'b0001; tick(); valid = '0;
    repeat (4) tick();
    chk("single_count", resp_log.size(), 1);
    chk("single_data", resp_log[0], 32'h00030000);

    // Signed operands
    resp_log.delete();
    set_op(1, 32'hFFFE8000, 32'h00020000);
    valid = 4'b0010; tick();
    set_op(2, 32'hFFFF0000, 32'hFFFF0000);
    valid = 4'b0100; tick(); valid = '0;
    repeat (4) tick();
    chk("signed_count", resp_log.size(), 2);
    chk("signed_neg", resp_log[0], 32'hFFFD0000);
    chk("signed_negneg", resp_log[1], 32'h00010000);

    // All four requesting continuously after a reset
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    grant_log.delete();
    valid = 4'b1111;
    repeat (8) tick();
    valid = '0;
    repeat (4) tick();
    chk("rr_count", grant_log.size(), 8);
    for (int i = 0; i < 8; i++) chk("rr_order", grant_log[i], i % 4);

    // Pointer wrap from 3 to 0 without an idle cycle
    grant_log.delete();
    valid = 4'b1000; tick();
    valid = 4'b0001; tick(); valid = '0;
    repeat (4) tick();
    chk("wrap_count", grant_log.size(), 2);
    chk("wrap_first", grant_log[0], 3);
    chk("wrap_second", grant_log[1], 0);

    // Reset with two operations in flight
    resp_log.delete();
    set_op(1, 32'h00010000, 32'h00010000);
    valid = 4'b0001; tick();
    valid = 4'b0010; tick(); valid = '0;
    rst = 1'b1; tick(); rst = 1'b0;
    grant_log.delete();
    valid = 4'b1111; tick(); tick(); valid = '0;
    repeat (4) tick();
    chk("flush_no_resp", resp_log.size(), 1);
    chk("flush_grants", grant_log.size(), 1);
    chk("flush_first_grant", grant_log[0], 0);

    // Random traffic; ungranted requesters hold their operands
    grant_total = 0;
    last_g = -1;
    while (grant_total < 10000 && cyc < 60000) begin
      for (int i = 0; i < NR; i++) begin
        if (!valid[i] || last_g == i) begin
          valid[i] = ($urandom_range(0, 3) != 0);
          set_op(i, $urandom, $urandom);
        end
      end
      tick();
    end
    valid = '0;
    repeat (LAT + 2) tick();
    chk("random_ops", (grant_total >= 10000), 1);
    chk("drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one multiplier (range 2..8).
REQ-002 Parameter MUL_LATENCY, default 3: accept-to-response latency in cycles (range 1..6).
REQ-003 Local W = `NUM_ALL_DIGITS, F = `NUM_FRAC_DIGITS; operands and results are package type fp (signed, W bits).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk_in  in  1  system clock, all state on rising edge.
REQ-006 rst_in  in  1  synchronous active-high reset.
REQ-007 req_valid_in  in  NUM_REQ  per-requester request valid.
REQ-008 req_a_in  in  NUM_REQ*W  packed operand A, requester i at bits [i*W +: W].
REQ-009 req_b_in  in  NUM_REQ*W  packed operand B, same packing.
REQ-010 req_ready_out  out  NUM_REQ  one-hot (or zero) grant; request i accepted when valid[i] & ready[i].
REQ-011 resp_valid_out  out  NUM_REQ  one-hot (or zero) result strobe addressed to the originating requester.
REQ-012 resp_data_out  out  W  product, meaningful only while any resp_valid_out bit is high.
REQ-013 busy_out  out  1  high while any accepted operation is in flight.

Function
REQ-014 req_ready_out SHALL be combinational from req_valid_in and rr_ptr; at most one bit high; zero when req_valid_in is zero.
REQ-015 Arbitration SHALL be round-robin: grant the first valid index searching rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ.
REQ-016 On an accepted request from index g, rr_ptr SHALL become (g+1) mod NUM_REQ next cycle (NUM_REQ-1 wraps to 0); rr_ptr is unchanged when nothing is accepted.
REQ-017 At most one request is accepted per cycle; throughput one multiply per cycle; there is no response backpressure.
REQ-018 A request accepted at edge T SHALL produce resp_valid_out[g]=1 and resp_data_out during the cycle after edge T+MUL_LATENCY-1 (i.e. exactly MUL_LATENCY cycles after acceptance).
REQ-019 Responses SHALL return in acceptance order; each pipeline stage carries valid bit, requester tag ($clog2(NUM_REQ) bits) and data.
REQ-020 Product SHALL be the full 2W-bit signed product of a and b, arithmetically shifted right by F, truncated to the low W bits (round toward negative infinity, overflow wraps).
REQ-021 A requester holding req_valid_in high while not granted SHALL keep its operands stable; the block does not latch ungranted operands.
REQ-022 busy_out SHALL equal the OR of all pipeline-stage valid bits.
REQ-023 Simultaneous acceptance and retirement in the same cycle SHALL both occur with no bubble.

Reset
REQ-024 rst_in SHALL clear rr_ptr to 0, all stage valid bits to 0, tags and data to 0.
REQ-025 During and in the cycle after rst_in, req_ready_out, resp_valid_out and busy_out SHALL be 0; resp_data_out SHALL be 0.
REQ-026 Reset mid-operation SHALL discard all in-flight operations; no response for them is ever issued.

Structure
REQ-027 Type fp and macros NUM_ALL_DIGITS/NUM_FRAC_DIGITS come from the shared fixed-point package; the block SHALL NOT redefine them.
REQ-028 Multiplication SHALL be in sub-module fp_mul_pipe (parameters W, F, MUL_LATENCY, TAG_W), pipelining the signed product and tag; fp_mul_arbiter holds only arbitration and rr_ptr.
REQ-029 A signed-correct fp_mul helper function SHALL be added to the package for bench reference modelling.

Verification (bench config W=32, F=16, NUM_REQ=4, MUL_LATENCY=3)
REQ-030 Single request: req 0 a=0x00018000 (1.5), b=0x00020000 (2.0) -> resp_valid_out=0001 exactly 3 cycles later, data 0x00030000.
REQ-031 Signed: a=0xFFFE8000 (-1.5), b=0x00020000 -> 0xFFFD0000 (-3.0); a=b=0xFFFF0000 (-1) -> 0x00010000.
REQ-032 All four valid continuously for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3; responses same order, one per cycle, busy_out high throughout.
REQ-033 Only req 3 then req 0 valid -> grant 3, rr_ptr wraps to 0, next grant 0 with no idle cycle.
REQ-034 Assert rst_in 1 cycle after accepting 2 ops -> no resp_valid_out ever for them, busy_out 0, next grant from index 0.
REQ-035 Random 10k ops vs package reference -> every result matches, per-requester order preserved, no requester starved over NUM_REQ consecutive grants.
